// File: rtl/memory_bus_wait.sv
// Memory bus router: decodes the CPU address into a bank, applies per-bank
// wait states, waits on the bank's ready (with a timeout), and returns a
// one-cycle ready pulse to the CPU. Unmapped or timed-out accesses complete
// with bus_error set.
module memory_bus_wait #(
  parameter int unsigned                    ADDR_WIDTH   = 16,
  parameter int unsigned                    DATA_WIDTH   = 8,
  parameter int unsigned                    BANK_BITS    = 2,
  parameter logic [4*(2**BANK_BITS)-1:0]    WAIT_CYCLES  = '0,
  parameter logic [(2**BANK_BITS)-1:0]      BANK_PRESENT = '1,
  parameter int unsigned                    TIMEOUT      = 255
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [ADDR_WIDTH-1:0]                   address,
  input  logic [DATA_WIDTH-1:0]                   data_in,
  input  logic                                    write_enable,
  input  logic                                    bus_enable,
  output logic [DATA_WIDTH-1:0]                   data_out,
  output logic                                    ready,
  output logic                                    bus_error,
  output logic [ADDR_WIDTH-BANK_BITS-1:0]         bank_address,
  output logic [DATA_WIDTH-1:0]                   bank_data_out,
  output logic [(2**BANK_BITS)-1:0]               bank_select,
  output logic                                    bank_write_enable,
  output logic                                    bank_read_enable,
  input  logic [(2**BANK_BITS)*DATA_WIDTH-1:0]    bank_data_in,
  input  logic [(2**BANK_BITS)-1:0]               bank_ready
);

  localparam int unsigned NUM_BANKS = 2**BANK_BITS;
  localparam int unsigned OFFS_W    = ADDR_WIDTH - BANK_BITS;
  localparam logic [7:0]  TIMEOUT_L = TIMEOUT[7:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [BANK_BITS-1:0]   bank_q, bank_d;
  logic                   we_q, we_d;
  logic                   err_q, err_d;
  logic [3:0]             wait_q, wait_d;
  logic [7:0]             stall_q, stall_d;
  logic [NUM_BANKS-1:0]   bank_sel_q, bank_sel_d;
  logic [OFFS_W-1:0]      bank_addr_q, bank_addr_d;
  logic [DATA_WIDTH-1:0]  bank_wdata_q, bank_wdata_d;
  logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;

  logic [BANK_BITS-1:0]   req_bank;
  logic [3:0]             wait_load;
  logic [DATA_WIDTH-1:0]  rdata_sel;

  assign req_bank = address[ADDR_WIDTH-1 -: BANK_BITS];

  // Wait-state count for the bank being requested.
  always_comb begin
    wait_load = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (req_bank == b[BANK_BITS-1:0]) wait_load = WAIT_CYCLES[4*b +: 4];
    end
  end

  // Read data slice of the latched bank.
  always_comb begin
    rdata_sel = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (bank_q == b[BANK_BITS-1:0]) rdata_sel = bank_data_in[b*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state and datapath update for the transaction sequencer.
  always_comb begin
    state_d      = state_q;
    bank_d       = bank_q;
    we_d         = we_q;
    err_d        = err_q;
    wait_d       = wait_q;
    stall_d      = stall_q;
    bank_sel_d   = bank_sel_q;
    bank_addr_d  = bank_addr_q;
    bank_wdata_d = bank_wdata_q;
    data_out_d   = data_out_q;

    case (state_q)
      S_IDLE: begin
        if (bus_enable) begin
          bank_d       = req_bank;
          we_d         = write_enable;
          bank_addr_d  = address[OFFS_W-1:0];
          bank_wdata_d = data_in;
          stall_d      = '0;
          if (!BANK_PRESENT[req_bank]) begin
            err_d      = 1'b1;
            bank_sel_d = '0;
            state_d    = S_DONE;
            if (!write_enable) data_out_d = '1;
          end else begin
            err_d      = 1'b0;
            bank_sel_d = NUM_BANKS'(1) << req_bank;
            wait_d     = wait_load;
            state_d    = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else if (bank_ready[bank_q]) begin
          state_d = S_ACCESS;
        end else begin
          stall_d = stall_q + 8'd1;
          if ((TIMEOUT != 0) && (stall_d == TIMEOUT_L)) begin
            err_d      = 1'b1;
            bank_sel_d = '0;
            state_d    = S_DONE;
            if (!we_q) data_out_d = '1;
          end
        end
      end

      S_ACCESS: begin
        if (!we_q) data_out_d = rdata_sel;
        bank_sel_d = '0;
        state_d    = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      bank_q       <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      wait_q       <= '0;
      stall_q      <= '0;
      bank_sel_q   <= '0;
      bank_addr_q  <= '0;
      bank_wdata_q <= '0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      we_q         <= we_d;
      err_q        <= err_d;
      wait_q       <= wait_d;
      stall_q      <= stall_d;
      bank_sel_q   <= bank_sel_d;
      bank_addr_q  <= bank_addr_d;
      bank_wdata_q <= bank_wdata_d;
      data_out_q   <= data_out_d;
    end
  end

  assign ready             = (state_q == S_DONE);
  assign bus_error         = (state_q == S_DONE) && err_q;
  assign bank_write_enable = (state_q == S_ACCESS) && we_q;
  assign bank_read_enable  = (state_q == S_ACCESS) && !we_q;
  assign bank_select       = bank_sel_q;
  assign bank_address      = bank_addr_q;
  assign bank_data_out     = bank_wdata_q;
  assign data_out          = data_out_q;

endmodule

// File: tb/tb_memory_bus_wait.sv
// Bench for memory_bus_wait: bank 0 W=0, bank 1 W=3, bank 2 W=0,
// bank 3 unmapped, timeout 255.
module tb_memory_bus_wait;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  data_in;
  logic        write_enable;
  logic        bus_enable;
  logic [7:0]  data_out;
  logic        ready;
  logic        bus_error;
  logic [13:0] bank_address;
  logic [7:0]  bank_data_out;
  logic [3:0]  bank_select;
  logic        bank_write_enable;
  logic        bank_read_enable;
  logic [31:0] bank_data_in;
  logic [3:0]  bank_ready;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [7:0]  cur_dout;

  int unsigned WT[4] = '{0, 3, 0, 0};
  bit          PR[4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wd;
    logic [7:0]  rd;
    int unsigned dst;
    int unsigned lat;
    logic        err;
    logic [7:0]  dout;
  } vec_t;

  vec_t vec[10];

  memory_bus_wait #(
    .ADDR_WIDTH   (16),
    .DATA_WIDTH   (8),
    .BANK_BITS    (2),
    .WAIT_CYCLES  (16'h0030),
    .BANK_PRESENT (4'b0111),
    .TIMEOUT      (255)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .address           (address),
    .data_in           (data_in),
    .write_enable      (write_enable),
    .bus_enable        (bus_enable),
    .data_out          (data_out),
    .ready             (ready),
    .bus_error         (bus_error),
    .bank_address      (bank_address),
    .bank_data_out     (bank_data_out),
    .bank_select       (bank_select),
    .bank_write_enable (bank_write_enable),
    .bank_read_enable  (bank_read_enable),
    .bank_data_in      (bank_data_in),
    .bank_ready        (bank_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level expectation from the latency/error rules.
  function automatic void model(input logic [15:0] addr, input logic we, input logic [7:0] rd,
                                input int unsigned dst, output int unsigned lat,
                                output logic err, output logic [7:0] dout);
    int unsigned b = int'(addr[15:14]);
    dout = cur_dout;
    if (!PR[b]) begin
      lat = 1; err = 1'b1;
      if (!we) dout = 8'hFF;
    end else if (dst < 255) begin
      lat = 3 + WT[b] + dst; err = 1'b0;
      if (!we) dout = rd;
    end else begin
      lat = 1 + WT[b] + 255; err = 1'b1;
      if (!we) dout = 8'hFF;
    end
  endfunction

  // Issue one request (called #1 after a rising edge) and check every cycle
  // up to one past the expected ready pulse.
  task automatic run_txn(input string tag, input logic [15:0] addr, input logic we,
                         input logic [7:0] wd, input logic [7:0] rd, input int unsigned dst,
                         input int unsigned lat, input logic err, input logic [7:0] dout);
    int unsigned b = int'(addr[15:14]);
    logic [31:0] bdi;
    logic [3:0]  nb;
    logic [3:0]  onehot;
    onehot = 4'b0001 << b;
    bdi = $urandom;
    bdi[b*8 +: 8] = rd;
    bank_data_in = bdi;
    address = addr; write_enable = we; data_in = wd; bus_enable = 1'b1;
    bank_ready = 4'($urandom);
    @(posedge clk); #1;
    bus_enable = 1'b0;
    address = 16'($urandom); data_in = 8'($urandom); write_enable = 1'($urandom);
    for (int unsigned k = 1; k <= lat + 1; k++) begin
      nb = 4'($urandom);
      nb[b] = (k >= 1 + WT[b] + dst);
      bank_ready = nb;
      chk({tag, "/ready"}, 32'(ready), 32'(k == lat));
      if (k == lat) begin
        chk({tag, "/bus_error"}, 32'(bus_error), 32'(err));
        chk({tag, "/data_out"}, 32'(data_out), 32'(dout));
      end
      chk({tag, "/wr_strobe"}, 32'(bank_write_enable), 32'(we && !err && k == lat - 1));
      chk({tag, "/rd_strobe"}, 32'(bank_read_enable), 32'(!we && !err && k == lat - 1));
      chk({tag, "/bank_select"}, 32'(bank_select), (PR[b] && k < lat) ? 32'(onehot) : 32'd0);
      if (PR[b] && k < lat) begin
        chk({tag, "/bank_address"}, 32'(bank_address), 32'(addr[13:0]));
        chk({tag, "/bank_data_out"}, 32'(bank_data_out), 32'(wd));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [15:0] ra;
    logic        rwe;
    logic [7:0]  rwd, rrd, edout;
    int unsigned rdst, elat;
    logic        eerr;

    vec[0] = '{16'h0012, 1'b0, 8'h00, 8'h5A,   0,   3, 1'b0, 8'h5A};
    vec[1] = '{16'h4005, 1'b1, 8'hC3, 8'h99,   0,   6, 1'b0, 8'h5A};
    vec[2] = '{16'hC000, 1'b0, 8'h00, 8'h12,   0,   1, 1'b1, 8'hFF};
    vec[3] = '{16'h8000, 1'b0, 8'h00, 8'h44, 255, 256, 1'b1, 8'hFF};
    vec[4] = '{16'h8ABC, 1'b0, 8'h00, 8'h33,  99, 102, 1'b0, 8'h33};
    vec[5] = '{16'hC123, 1'b1, 8'h77, 8'h00,   0,   1, 1'b1, 8'h33};
    vec[6] = '{16'h7FFF, 1'b0, 8'h00, 8'h81,   2,   8, 1'b0, 8'h81};
    vec[7] = '{16'h8001, 1'b1, 8'hEE, 8'h00, 255, 256, 1'b1, 8'h81};
    vec[8] = '{16'h0123, 1'b0, 8'h00, 8'h11, 254, 257, 1'b0, 8'h11};
    vec[9] = '{16'h3FFF, 1'b1, 8'h42, 8'h00,   5,   8, 1'b0, 8'h11};

    reset = 1'b0; address = '0; data_in = '0; write_enable = 1'b0; bus_enable = 1'b0;
    bank_data_in = '0; bank_ready = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset/ready", 32'(ready), 32'd0);
    chk("reset/bus_error", 32'(bus_error), 32'd0);
    chk("reset/data_out", 32'(data_out), 32'd0);
    chk("reset/bank_select", 32'(bank_select), 32'd0);
    chk("reset/strobes", 32'({bank_write_enable, bank_read_enable}), 32'd0);
    chk("reset/bank_address", 32'(bank_address), 32'd0);
    chk("reset/bank_data_out", 32'(bank_data_out), 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    cur_dout = 8'h00;

    for (int i = 0; i < 10; i++) begin
      run_txn($sformatf("vec%0d", i), vec[i].addr, vec[i].we, vec[i].wd, vec[i].rd,
              vec[i].dst, vec[i].lat, vec[i].err, vec[i].dout);
      cur_dout = vec[i].dout;
    end

    // Reset in the middle of a bank-1 wait sequence.
    address = 16'h4000; write_enable = 1'b0; bus_enable = 1'b1; bank_ready = '1;
    @(posedge clk); #1;
    bus_enable = 1'b0;
    @(posedge clk); #1;
    chk("midrst/in_wait_select", 32'(bank_select), 32'h2);
    reset = 1'b0;
    #1;
    chk("midrst/ready", 32'(ready), 32'd0);
    chk("midrst/bus_error", 32'(bus_error), 32'd0);
    chk("midrst/data_out", 32'(data_out), 32'd0);
    chk("midrst/bank_select", 32'(bank_select), 32'd0);
    chk("midrst/strobes", 32'({bank_write_enable, bank_read_enable}), 32'd0);
    chk("midrst/bank_address", 32'(bank_address), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("midrst/held_no_ready", 32'({ready, bank_write_enable, bank_read_enable}), 32'd0);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    cur_dout = 8'h00;
    run_txn("postrst", 16'h0020, 1'b0, 8'h00, 8'hA5, 0, 3, 1'b0, 8'hA5);
    cur_dout = 8'hA5;

    // Back-to-back reads with bus_enable held high.
    address = 16'h0001; write_enable = 1'b0; bus_enable = 1'b1; bank_ready = '1;
    bank_data_in = 32'h0000_0066;
    @(posedge clk); #1;
    for (int unsigned k = 1; k <= 8; k++) begin
      if (k == 5) bus_enable = 1'b0;
      chk("b2b/ready", 32'(ready), 32'(k == 3 || k == 7));
      chk("b2b/rd_strobe", 32'(bank_read_enable), 32'(k == 2 || k == 6));
      if (k == 3 || k == 7) chk("b2b/data_out", 32'(data_out), 32'h66);
      @(posedge clk); #1;
    end
    cur_dout = 8'h66;

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra   = 16'($urandom);
      rwe  = 1'($urandom);
      rwd  = 8'($urandom);
      rrd  = 8'($urandom);
      rdst = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 6);
      model(ra, rwe, rrd, rdst, elat, eerr, edout);
      run_txn($sformatf("rnd%0d", i), ra, rwe, rwd, rrd, rdst, elat, eerr, edout);
      cur_dout = edout;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_bus_wait.md
Name: memory_bus_wait

Overview:
- Parametrised memory bus router with a wait-state handshake.
- Decodes the top BANK_BITS of the CPU address into one of NUM_BANKS banks and routes reads and writes to that bank.
- Inserts per-bank programmable wait states and honours a per-bank ready input for slow devices such as SPI EEPROM.
- Reports unmapped or timed-out accesses to the CPU via ready/bus_error. Sits between the CPU core and the ROM/RAM/peripheral/block-RAM banks.

Parameters:
- ADDR_WIDTH, 16, CPU address width.
- DATA_WIDTH, 8, data width.
- BANK_BITS, 2, address MSBs used for bank decode; NUM_BANKS = 2**BANK_BITS.
- WAIT_CYCLES, 0, packed 4 bits per bank; bank b uses WAIT_CYCLES[4b+3:4b].
- BANK_PRESENT, all-ones, NUM_BANKS-bit mask; 0 = bank unmapped.
- TIMEOUT, 255, 8-bit maximum stall cycles waiting on bank_ready; 0 disables the timeout.

Ports:
- clk  input  1  single system clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- address  input  ADDR_WIDTH  CPU address.
- data_in  input  DATA_WIDTH  CPU write data.
- write_enable  input  1  1 = write, 0 = read; sampled with bus_enable.
- bus_enable  input  1  CPU request.
- data_out  output  DATA_WIDTH  registered read data.
- ready  output  1  one-cycle completion pulse.
- bus_error  output  1  error flag, valid only while ready=1.
- bank_address  output  ADDR_WIDTH-BANK_BITS  latched in-bank address.
- bank_data_out  output  DATA_WIDTH  latched write data.
- bank_select  output  NUM_BANKS  one-hot selected bank.
- bank_write_enable  output  1  one-cycle write strobe.
- bank_read_enable  output  1  one-cycle read strobe.
- bank_data_in  input  NUM_BANKS*DATA_WIDTH  flat read data; bank b occupies slice b.
- bank_ready  input  NUM_BANKS  per-bank ready; tie to 1 for zero-latency banks.

Behaviour:
- Reset (reset=0, async): state IDLE; ready=0, bus_error=0, data_out=0, bank_select=0, both strobes 0, bank_address=0, bank_data_out=0, all counters 0.
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE, bus_enable=0: stay in IDLE.
- IDLE, bus_enable=1 (cycle N):
  - Latch address, data_in and write_enable.
  - Bank b = address[ADDR_WIDTH-1 -: BANK_BITS].
  - If BANK_PRESENT[b]=0: go to DONE with error; bank_select stays 0.
  - Otherwise: set bank_select one-hot b, load wait counter with WAIT_CYCLES for b, clear stall counter, go to WAIT.
- WAIT:
  - wait counter != 0: decrement it.
  - wait counter == 0 and bank_ready[b]=1: go to ACCESS.
  - wait counter == 0 and bank_ready[b]=0: increment stall counter. When this is the TIMEOUT-th stall cycle (TIMEOUT != 0), go to DONE with error.
- ACCESS (exactly one cycle):
  - Write: bank_write_enable=1.
  - Read: bank_read_enable=1, and data_out is loaded from slice b of bank_data_in at the end of the cycle.
  - Go to DONE.
- DONE (exactly one cycle):
  - ready=1; bus_error=1 on an error path, else 0.
  - On an error read, data_out = all-ones. On an error write, no write strobe is issued.
  - bank_select clears; return to IDLE.
  - A request is never accepted in DONE. The CPU must drop bus_enable on the ready cycle or a new transaction starts in the following IDLE cycle.
- Latency, normal path: request sampled at N, ready at N+3+W.
- Latency, unmapped bank: ready at N+1.
- Latency, timeout: ready at N+1+W+TIMEOUT.
- Holding: bank_address, bank_data_out and bank_select are stable from N+1 through ACCESS. data_out holds until the next read or error completion. Writes do not modify data_out.
- The CPU may change address, data_in and write_enable after cycle N; latched values are used.
- bank_ready of non-selected banks is ignored.
- If bank_ready rises on the same cycle the stall counter would expire, the ACCESS path wins.
- Reset asserted mid-transaction aborts it immediately: no strobe, no ready.

Test Plan:
- WAIT_CYCLES=0, bank 0 read at 0x0012, bank_data_in slice0=0x5A, bank_ready=all-ones -> bank_read_enable at N+2, ready at N+3 with data_out=0x5A, bus_error=0.
- Bank 1 with W=3, write 0xC3 to 0x4005 -> bank_select=0b0010 and bank_address=0x0005 from N+1; one bank_write_enable pulse at N+5 with bank_data_out=0xC3; ready at N+6; data_out unchanged.
- BANK_PRESENT=4'b0111, read at 0xC000 -> ready at N+1, bus_error=1, data_out=0xFF, no strobes, bank_select=0 throughout.
- TIMEOUT=255, W=0, bank 2 with bank_ready held 0 -> ready at N+256, bus_error=1, no strobe. Repeat with bank_ready rising at N+100 -> ACCESS at N+101, ready at N+102, bus_error=0.
- Reset asserted during WAIT -> all outputs 0 within the same cycle; after release, a fresh bank 0 read completes normally at N+3.
- Back-to-back reads with bus_enable held high -> second request is sampled on the IDLE cycle after DONE; two ready pulses with no overlap.
